fifo_rr_arbiter: RTL and testbench

Round-robin pop arbiter that drains the eight virtual-channel source FIFOs into a single destination FIFO. It sits between the FIFO bank and the downstream FIFO, runs only while the link FSM reports the ACTIVE state, and honours the destination's almost-full flag. It also applies a per-channel burst limit so that one busy FIFO cannot starve the others.

---
 rtl/fifo_rr_arbiter_if.sv | 20 ++
 rtl/fifo_rr_arbiter.sv | 66 ++++++
 tb/tb_fifo_rr_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: source-bank / destination-FIFO signals around the round-robin pop arbiter
interface fifo_rr_arbiter_if #(parameter int DATA_WIDTH = 10);
  logic                    active;
  logic [7:0]              empty;
  logic [8*DATA_WIDTH-1:0] data_in;
  logic                    dest_almost_full;
  logic [7:0]              pop;
  logic                    push;
  logic [DATA_WIDTH-1:0]   data_out;
  logic [1:0]              arb_state;
  logic                    idle_out;
  modport master (
    input  active, empty, data_in, dest_almost_full,
    output pop, push, data_out, arb_state, idle_out
  );
  modport slave (
    output active, empty, data_in, dest_almost_full,
    input  pop, push, data_out, arb_state, idle_out
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: drains eight source FIFOs into one destination with round-robin priority and a burst cap
module fifo_rr_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int BURST      = 4
) (
  input logic               clk,
  input logic               reset,
  fifo_rr_arbiter_if.master bus
);
  typedef enum logic [1:0] {OFF = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;
  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d, cur_q, cur_d, sel_q, sel_d, sel;
  logic [3:0] cnt_q, cnt_d, cnt_n;
  logic       lock_q, lock_d, push_q, fire;
  // Descending scan leaves the lowest offset from ptr as the winner; a live lock overrides it.
  always_comb begin
    sel = ptr_q;
    for (int k = 7; k >= 0; k--)
      if (!bus.empty[ptr_q + 3'(k)]) sel = ptr_q + 3'(k);
    if (lock_q && !bus.empty[cur_q]) sel = cur_q;
  end
  assign fire = (state_q == RUN) && bus.active && !bus.dest_almost_full && !(&bus.empty);
  assign bus.pop = fire ? 8'd1 << sel : 8'd0;
  always_comb begin
    state_d = !bus.active ? OFF : (state_q == OFF) ? RUN : bus.dest_almost_full ? STALL : RUN;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    sel_d   = sel_q;
    cnt_n   = (lock_q && sel == cur_q) ? cnt_q + 4'd1 : 4'd1;
    if (fire) begin
      cur_d  = sel;
      sel_d  = sel;
      ptr_d  = sel + 3'd1;
      lock_d = cnt_n != 4'(BURST);
      cnt_d  = (cnt_n == 4'(BURST)) ? 4'd0 : cnt_n;
    end else if (lock_q && bus.empty[cur_q]) begin
      lock_d = 1'b0;
      cnt_d  = 4'd0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OFF;
      ptr_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      sel_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      sel_q   <= sel_d;
      push_q  <= fire;
    end
  end
  assign bus.push      = push_q;
  assign bus.data_out  = push_q ? bus.data_in[sel_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.arb_state = state_q;
  assign bus.idle_out  = (&bus.empty) & ~push_q;
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: randomized and directed scoreboard bench for the round-robin FIFO pop arbiter
module tb_fifo_rr_arbiter;
  localparam int DW = 10;
  localparam int BURST = 4;
  logic clk = 0;
  logic reset = 0;
  fifo_rr_arbiter_if #(.DATA_WIDTH(DW)) bus();
  fifo_rr_arbiter #(.DATA_WIDTH(DW), .BURST(BURST)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  logic [DW-1:0] q[8][$];
  logic [DW-1:0] data_reg[8];
  logic [DW-1:0] exp_q[$];
  int order[$];
  logic [7:0] pop_s = 0;
  int n_chk = 0, n_fail = 0, rst_cnt = 0;
  always @(negedge reset) rst_cnt++;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Behavioural reference: channel choice from round-robin and burst rules, stream words from the source queues
  int m_st = 0, m_ptr = 0, m_cur = 0, m_cnt = 0, m_seen = 0;
  bit m_lock = 0, m_push = 0;
  always @(negedge clk) begin
    logic [7:0] e;
    int s;
    bit f;
    e = bus.empty;
    if (!reset || rst_cnt != m_seen) begin
      m_st = 0; m_ptr = 0; m_cur = 0; m_cnt = 0; m_lock = 0; m_push = 0;
    end
    m_seen = rst_cnt;
    s = -1;
    if (m_lock && !e[m_cur]) s = m_cur;
    else for (int k = 0; k < 8; k++) if (s < 0 && !e[(m_ptr + k) % 8]) s = (m_ptr + k) % 8;
    f = reset && m_st == 1 && bus.active && !bus.dest_almost_full && s >= 0;
    chk("pop", bus.pop, f ? (1 << s) : 0);
    chk("arb_state", bus.arb_state, m_st);
    chk("push", bus.push, m_push);
    chk("idle_out", bus.idle_out, (e == 8'hFF) && !m_push);
    pop_s = bus.pop;
    if (reset) begin
      if (f) begin
        exp_q.push_back(q[s][0]);
        order.push_back(s);
        m_cnt = (m_lock && s == m_cur) ? m_cnt + 1 : 1;
        m_cur = s;
        m_ptr = (s + 1) % 8;
        m_lock = m_cnt != BURST;
        if (!m_lock) m_cnt = 0;
      end else if (m_lock && e[m_cur]) begin
        m_lock = 0;
        m_cnt = 0;
      end
      m_st = !bus.active ? 0 : m_st == 0 ? 1 : bus.dest_almost_full ? 2 : 1;
      m_push = f;
    end
  end
  int mon_seen = 0;
  always @(negedge clk) begin
    if (!reset || rst_cnt != mon_seen) exp_q.delete();
    mon_seen = rst_cnt;
    if (bus.push) begin
      if (exp_q.size() == 0) chk("sb_underflow", bus.push, 0);
      else chk("data_out", bus.data_out, exp_q.pop_front());
    end else chk("data_out_idle", bus.data_out, 0);
  end
  task automatic update_bus();
    for (int i = 0; i < 8; i++) begin
      bus.empty[i] = q[i].size() == 0;
      bus.data_in[i*DW +: DW] = data_reg[i];
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      if (pop_s[i] && q[i].size() > 0) data_reg[i] = q[i].pop_front();
    update_bus();
  endtask
  task automatic load(input int ch, input int n);
    for (int k = 0; k < n; k++) q[ch].push_back(DW'($urandom));
    update_bus();
  endtask
  task automatic pulse_reset();
    #1 reset = 0;
    #1;
    chk("rst_pop", bus.pop, 0);
    chk("rst_push", bus.push, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_state", bus.arb_state, 0);
    chk("rst_idle", bus.idle_out, bus.empty == 8'hFF);
    #1 reset = 1;
  endtask
  task automatic chk_order(input string nm, input int o, input int k, input int exp);
    chk(nm, (order.size() > o + k) ? order[o + k] : -1, exp);
  endtask
  int o;
  int e2[12] = '{2, 2, 2, 2, 5, 5, 5, 5, 2, 2, 5, 5};
  int e3[3] = '{6, 7, 0};
  initial begin
    bus.active = 0;
    bus.dest_almost_full = 0;
    for (int i = 0; i < 8; i++) data_reg[i] = '0;
    update_bus();
    repeat (3) tick();
    chk("reset_state", bus.arb_state, 0);
    reset = 1;
    bus.active = 1;
    q[0].push_back(10'h0A);
    q[0].push_back(10'h0B);
    q[0].push_back(10'h0C);
    update_bus();
    repeat (8) tick();
    chk("t1_idle", bus.idle_out, 1);
    pulse_reset();
    load(2, 6);
    load(5, 6);
    o = order.size();
    repeat (16) tick();
    for (int k = 0; k < 12; k++) chk_order("t2_order", o, k, e2[k]);
    o = order.size();
    load(6, 1);
    load(7, 1);
    load(0, 1);
    repeat (6) tick();
    for (int k = 0; k < 3; k++) chk_order("t3_wrap", o, k, e3[k]);
    load(3, 10);
    repeat (2) tick();
    bus.dest_almost_full = 1;
    repeat (3) tick();
    bus.dest_almost_full = 0;
    repeat (12) tick();
    load(1, 8);
    load(4, 3);
    repeat (2) tick();
    bus.active = 0;
    repeat (5) tick();
    bus.active = 1;
    repeat (16) tick();
    load(4, 10);
    load(0, 10);
    repeat (3) tick();
    pulse_reset();
    o = order.size();
    repeat (3) tick();
    chk_order("t6_first_after_reset", o, 0, 0);
    repeat (30) tick();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, 7), $urandom_range(1, 2));
      if ($urandom_range(0, 29) == 0) bus.active = ~bus.active;
      bus.dest_almost_full = $urandom_range(0, 7) == 0;
      tick();
    end
    bus.active = 1;
    bus.dest_almost_full = 0;
    for (int c = 0; c < 3000 && bus.empty != 8'hFF; c++) tick();
    repeat (4) tick();
    chk("drain_empty", bus.empty, 8'hFF);
    chk("drain_scoreboard", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
